// File: rtl/time_alarm_core_if.sv
// rtl/time_alarm_core_if.sv - pulse inputs and time/alarm outputs of time_alarm_core
interface time_alarm_core_if;
    logic       tick_1hz;
    logic       sec_adj;
    logic       min_adj;
    logic       hrs_adj;
    logic       al_adj;
    logic       al_toggle;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [3:0] hours;
    logic [5:0] al_minutes;
    logic [3:0] al_hours;
    logic       al_on;
    logic       ringing;
    logic       bell_visible;
    logic       buzzer_out;

    modport master (
        output tick_1hz, sec_adj, min_adj, hrs_adj, al_adj, al_toggle,
        input  seconds, minutes, hours, al_minutes, al_hours,
        input  al_on, ringing, bell_visible, buzzer_out
    );

    modport slave (
        input  tick_1hz, sec_adj, min_adj, hrs_adj, al_adj, al_toggle,
        output seconds, minutes, hours, al_minutes, al_hours,
        output al_on, ringing, bell_visible, buzzer_out
    );
endinterface

// File: rtl/time_alarm_core.sv
// rtl/time_alarm_core.sv - 12-hour timekeeping, alarm FSM and gated buzzer tone
// Optional snooze state enabled by defining TAC_SNOOZE_EN.
module time_alarm_core #(
    parameter int TONE_HALF      = 5000,
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 120
) (
    input  logic               clk,
    input  logic               reset,
    time_alarm_core_if.slave   bus
);
    localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

    if (RING_SECONDS < 1 || RING_SECONDS > 255) begin : g_bad_ring
        $error("RING_SECONDS must be 1..255");
    end
    if (SNOOZE_SECONDS < 1 || SNOOZE_SECONDS > 255) begin : g_bad_snooze
        $error("SNOOZE_SECONDS must be 1..255");
    end

`ifdef TAC_SNOOZE_EN
    typedef enum logic [2:0] {IDLE, ARMED, RINGING, DONE, SNOOZE} state_t;
`else
    typedef enum logic [1:0] {IDLE, ARMED, RINGING, DONE} state_t;
`endif

    state_t        state, state_next;
    logic [5:0]    sec_r, min_r, al_min_r;
    logic [3:0]    hrs_r, al_hrs_r;
    logic          tick_pending;
    logic [7:0]    ring_cnt, ring_cnt_next;
    logic          beep_phase, beep_next;
    logic [TW-1:0] tone_cnt;
    logic          tone, tone_next;
    logic          al_on_r, ringing_r, bell_r, buzzer_r;

    logic any_adj, apply_tick, match, snooze_req, al_step;

    assign any_adj    = bus.sec_adj | bus.min_adj | bus.hrs_adj | bus.al_adj;
    assign apply_tick = (bus.tick_1hz | tick_pending) & ~any_adj;
    assign match      = (hrs_r == al_hrs_r) && (min_r == al_min_r);
`ifdef TAC_SNOOZE_EN
    assign snooze_req = bus.al_adj && (state == RINGING);
`else
    assign snooze_req = 1'b0;
`endif
    // A snooze request consumes al_adj instead of moving the alarm time.
    assign al_step   = bus.al_adj & ~snooze_req;
    assign tone_next = tone ^ (tone_cnt == TW'(TONE_HALF - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            sec_r        <= '0;
            min_r        <= '0;
            hrs_r        <= '0;
            al_min_r     <= '0;
            al_hrs_r     <= '0;
            tick_pending <= 1'b0;
        end else begin
            tick_pending <= any_adj ? (bus.tick_1hz | tick_pending)
                                    : (bus.tick_1hz & tick_pending);
            if (apply_tick) begin
                if (sec_r == 6'd59) begin
                    sec_r <= '0;
                    if (min_r == 6'd59) begin
                        min_r <= '0;
                        hrs_r <= (hrs_r == 4'd11) ? 4'd0 : hrs_r + 4'd1;
                    end else begin
                        min_r <= min_r + 6'd1;
                    end
                end else begin
                    sec_r <= sec_r + 6'd1;
                end
            end
            // apply_tick and the adjusts are mutually exclusive, so no field is written twice.
            if (bus.sec_adj) sec_r <= (sec_r == 6'd59) ? 6'd0 : sec_r + 6'd1;
            if (bus.min_adj) min_r <= (min_r == 6'd59) ? 6'd0 : min_r + 6'd1;
            if (bus.hrs_adj) hrs_r <= (hrs_r == 4'd11) ? 4'd0 : hrs_r + 4'd1;
            if (al_step) begin
                if (al_min_r >= 6'd50) begin
                    al_min_r <= al_min_r - 6'd50;
                    al_hrs_r <= (al_hrs_r == 4'd11) ? 4'd0 : al_hrs_r + 4'd1;
                end else begin
                    al_min_r <= al_min_r + 6'd10;
                end
            end
        end
    end

`ifdef TAC_SNOOZE_EN
    logic [7:0] snooze_cnt, snooze_cnt_next;
    always_ff @(posedge clk) begin
        if (reset) snooze_cnt <= '0;
        else       snooze_cnt <= snooze_cnt_next;
    end
`endif

    always_comb begin
        state_next    = state;
        ring_cnt_next = ring_cnt;
        beep_next     = bus.tick_1hz ? ~beep_phase : beep_phase;
`ifdef TAC_SNOOZE_EN
        snooze_cnt_next = snooze_cnt;
`endif
        if (bus.al_toggle) begin
            state_next = (state == IDLE) ? ARMED : IDLE;
        end else begin
            case (state)
                IDLE: ;
                ARMED: if (match) begin
                    state_next    = RINGING;
                    ring_cnt_next = '0;
                    beep_next     = 1'b1;
                end
                RINGING: begin
                    if (snooze_req) begin
                        state_next = state_t'(3'd4);
`ifdef TAC_SNOOZE_EN
                        snooze_cnt_next = '0;
`endif
                    end else if (apply_tick) begin
                        if (ring_cnt == 8'(RING_SECONDS - 1)) state_next = DONE;
                        else ring_cnt_next = ring_cnt + 8'd1;
                    end
                end
                DONE: if (!match) state_next = ARMED;
`ifdef TAC_SNOOZE_EN
                SNOOZE: if (apply_tick) begin
                    if (snooze_cnt == 8'(SNOOZE_SECONDS - 1)) begin
                        state_next    = RINGING;
                        ring_cnt_next = '0;
                    end else begin
                        snooze_cnt_next = snooze_cnt + 8'd1;
                    end
                end
`endif
                default: state_next = IDLE;
            endcase
        end
    end

    // Status outputs are registered from next-state values so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ring_cnt   <= '0;
            beep_phase <= 1'b0;
            tone_cnt   <= '0;
            tone       <= 1'b0;
            al_on_r    <= 1'b0;
            ringing_r  <= 1'b0;
            bell_r     <= 1'b0;
            buzzer_r   <= 1'b0;
        end else begin
            state      <= state_next;
            ring_cnt   <= ring_cnt_next;
            beep_phase <= beep_next;
            tone_cnt   <= (tone_cnt == TW'(TONE_HALF - 1)) ? '0 : tone_cnt + 1'b1;
            tone       <= tone_next;
            al_on_r    <= (state_next != IDLE);
            ringing_r  <= (state_next == RINGING);
            bell_r     <= (state_next != IDLE) && ((state_next != RINGING) || beep_next);
            buzzer_r   <= (state_next == RINGING) && beep_next && tone_next;
        end
    end

    assign bus.seconds      = sec_r;
    assign bus.minutes      = min_r;
    assign bus.hours        = hrs_r;
    assign bus.al_minutes   = al_min_r;
    assign bus.al_hours     = al_hrs_r;
    assign bus.al_on        = al_on_r;
    assign bus.ringing      = ringing_r;
    assign bus.bell_visible = bell_r;
    assign bus.buzzer_out   = buzzer_r;
endmodule

// File: tb/tb_time_alarm_core.sv
// tb/tb_time_alarm_core.sv - scoreboard bench for time_alarm_core against a behavioural model
module tb_time_alarm_core;
    localparam int TH = 13;
    localparam int RS = 60;
    localparam int SS = 120;
    localparam int S_IDLE = 0, S_ARMED = 1, S_RING = 2, S_DONE = 3, S_SNOOZE = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    time_alarm_core_if bus();

    time_alarm_core #(.TONE_HALF(TH), .RING_SECONDS(RS), .SNOOZE_SECONDS(SS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [5:0] s;
        logic [5:0] m;
        logic [3:0] h;
        logic [5:0] am;
        logic [3:0] ah;
        logic       on;
        logic       rg;
        logic       bell;
        logic       bz;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;

    // Reference model: time as seconds-of-12h, alarm as minutes-of-12h.
    int t_sec = 0, al_tot = 0, st = S_IDLE, rcnt = 0, scnt = 0, k = 0;
    bit pend = 0, beep = 0;

    task automatic model(input bit rst, tk, sa, ma, ha, aa, at);
        int h, m, s, ah, amn;
        bit match, adj, snz, app;
        obs_t e;
        if (rst) begin
            t_sec = 0; al_tot = 0; st = S_IDLE; rcnt = 0; scnt = 0; k = 0; pend = 0; beep = 0;
            e = '0;
        end else begin
            h = t_sec / 3600; m = (t_sec / 60) % 60; s = t_sec % 60;
            ah = al_tot / 60; amn = al_tot % 60;
            match = (h == ah) && (m == amn);
            adj = sa | ma | ha | aa;
`ifdef TAC_SNOOZE_EN
            snz = aa && (st == S_RING);
`else
            snz = 0;
`endif
            app = (tk | pend) && !adj;
            pend = adj ? (tk | pend) : (tk & pend);
            if (sa) s = (s + 1) % 60;
            if (ma) m = (m + 1) % 60;
            if (ha) h = (h + 1) % 12;
            t_sec = h * 3600 + m * 60 + s;
            if (aa && !snz) al_tot = (al_tot + 10) % 720;
            if (app) t_sec = (t_sec + 1) % 43200;
            if (tk) beep = !beep;
            if (at) st = (st == S_IDLE) ? S_ARMED : S_IDLE;
            else if (st == S_ARMED && match) begin st = S_RING; rcnt = 0; beep = 1; end
            else if (st == S_RING && snz) begin st = S_SNOOZE; scnt = 0; end
            else if (st == S_RING && app) begin
                if (rcnt == RS - 1) st = S_DONE; else rcnt++;
            end
            else if (st == S_DONE && !match) st = S_ARMED;
            else if (st == S_SNOOZE && app) begin
                if (scnt == SS - 1) begin st = S_RING; rcnt = 0; end else scnt++;
            end
            k++;
            e.s = 6'(t_sec % 60); e.m = 6'((t_sec / 60) % 60); e.h = 4'(t_sec / 3600);
            e.am = 6'(al_tot % 60); e.ah = 4'(al_tot / 60);
            e.on = (st != S_IDLE);
            e.rg = (st == S_RING);
            e.bell = e.on && (!e.rg || beep);
            e.bz = e.rg && beep && (((k / TH) % 2) == 1);
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input bit rst, tk, sa, ma, ha, aa, at);
        @(negedge clk);
        reset = rst; bus.tick_1hz = tk; bus.sec_adj = sa; bus.min_adj = ma;
        bus.hrs_adj = ha; bus.al_adj = aa; bus.al_toggle = at;
        model(rst, tk, sa, ma, ha, aa, at);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic run_ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            step(0, 1, 0, 0, 0, 0, 0);
            idle(gap);
        end
    endtask

    task automatic settle;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    task automatic arm_at_0010;
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(1);
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.seconds, bus.minutes, bus.hours, bus.al_minutes, bus.al_hours,
                     bus.al_on, bus.ringing, bus.bell_visible, bus.buzzer_out};
                checks++;
                if (a === e) passed++;
                else $display("FAIL scoreboard cycle %0d: got %h expected %h", cyc, a, e);
            end
        end
    end

    initial begin : driver
        reset = 1'b1;
        bus.tick_1hz = 0; bus.sec_adj = 0; bus.min_adj = 0;
        bus.hrs_adj = 0; bus.al_adj = 0; bus.al_toggle = 0;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        settle();
        chk("reset_al_on", int'(bus.al_on), 0);
        chk("reset_buzzer", int'(bus.buzzer_out), 0);

        run_ticks(3661, 0);
        settle();
        chk("t3661_h", int'(bus.hours), 1);
        chk("t3661_m", int'(bus.minutes), 1);
        chk("t3661_s", int'(bus.seconds), 1);

        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 58; i++) step(0, 0, 1, 1, 0, 0, 0);
        run_ticks(1, 1);
        settle();
        chk("wrap_12h", int'({bus.hours, bus.minutes, bus.seconds}), 0);

        for (int i = 0; i < 60; i++) step(0, 0, 1, 0, 0, 0, 0);
        settle();
        chk("sec_adj_wrap_s", int'(bus.seconds), 0);
        chk("sec_adj_wrap_m", int'(bus.minutes), 0);

        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1, 0);
        settle();
        chk("al_adj6_min", int'(bus.al_minutes), 0);
        chk("al_adj6_hrs", int'(bus.al_hours), 1);

        step(1, 0, 0, 0, 0, 0, 0);
        run_ticks(5, 0);
        step(0, 1, 0, 1, 0, 0, 0);
        settle();
        chk("coinc_min", int'(bus.minutes), 1);
        chk("coinc_sec_held", int'(bus.seconds), 5);
        idle(1);
        settle();
        chk("coinc_sec_late", int'(bus.seconds), 6);

        arm_at_0010();
        run_ticks(600, 3);
        settle();
        chk("ring_start", int'(bus.ringing), 1);
        run_ticks(60, 3);
        settle();
        chk("ring_timeout", int'(bus.ringing), 0);
        chk("ring_armed_after", int'(bus.al_on), 1);
        run_ticks(30, 1);

        arm_at_0010();
        run_ticks(603, 2);
        step(0, 0, 0, 0, 0, 0, 1);
        settle();
        chk("toggle_al_on", int'(bus.al_on), 0);
        chk("toggle_buzzer", int'(bus.buzzer_out), 0);
        chk("toggle_bell", int'(bus.bell_visible), 0);

        arm_at_0010();
        run_ticks(602, 2);
        step(1, 0, 0, 0, 0, 0, 0);
        settle();
        chk("reset_mid_ring", int'({bus.al_on, bus.ringing, bus.bell_visible, bus.buzzer_out}), 0);

        arm_at_0010();
        run_ticks(603, 2);
        step(0, 0, 0, 0, 0, 1, 0);
        settle();
`ifdef TAC_SNOOZE_EN
        chk("snooze_al_min", int'(bus.al_minutes), 10);
        chk("snooze_silent", int'(bus.ringing), 0);
        run_ticks(SS, 1);
        settle();
        chk("snooze_resume", int'(bus.ringing), 1);
`else
        chk("nosnooze_al_min", int'(bus.al_minutes), 20);
        chk("nosnooze_ring", int'(bus.ringing), 1);
`endif

        for (int i = 0; i < 6000; i++) begin
            step(($urandom_range(1999) == 0),
                 ($urandom_range(2) == 0),
                 ($urandom_range(15) == 0),
                 ($urandom_range(15) == 0),
                 ($urandom_range(15) == 0),
                 ($urandom_range(15) == 0),
                 ($urandom_range(63) == 0));
        end
        idle(2);
        repeat (3) @(posedge clk);
        #3;
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/time_alarm_core.md
Name: time_alarm_core

Overview:
Timekeeping and alarm engine for the VGA analog clock. It takes the 1 Hz tick, the debounced button pulses and the alarm toggle, and maintains 12-hour time plus the alarm setting. It produces the time values consumed by the clock renderer, the bell-visibility flag and the gated buzzer tone. It sits between the clock dividers/debouncers and the renderer/buzzer pin.

Parameters:
TONE_HALF, 5000, clk cycles per half-period of the buzzer tone (31.5 MHz / 10000 = 3150 Hz).
RING_SECONDS, 60, number of 1 Hz ticks the alarm rings before auto-silencing (1..255).
SNOOZE_SECONDS, 120, snooze length in ticks (1..255); used only with TAC_SNOOZE_EN.

Ports:
clk  in  1  system clock, 31.5 MHz
reset  in  1  synchronous, active-high reset
tick_1hz  in  1  single-cycle pulse, once per second
sec_adj  in  1  debounced pulse: seconds +1
min_adj  in  1  debounced pulse: minutes +1
hrs_adj  in  1  debounced pulse: hours +1
al_adj  in  1  debounced pulse: alarm minutes +10
al_toggle  in  1  debounced pulse: alarm on/off
seconds  out  6  0..59
minutes  out  6  0..59
hours  out  4  0..11
al_minutes  out  6  0..59
al_hours  out  4  0..11
al_on  out  1  alarm armed (state != IDLE)
ringing  out  1  state == RINGING
bell_visible  out  1  bell icon enable for the renderer
buzzer_out  out  1  gated square-wave tone; needs an external driver

Behaviour:
- Interface: reset is synchronous and active-high; clock is clk. All outputs are registered.
- Reset: all time and alarm fields are 0, state is IDLE, every 1-bit output is 0, and all internal counters are 0.
- Time path (registered outputs update 1 cycle after the pulse):
  - tick: seconds +1. At 59 it wraps to 0 and carries minutes +1. Minutes at 59 wrap to 0 and carry hours +1. Hours at 11 wrap to 0.
  - sec_adj, min_adj and hrs_adj each increment only their own field, wrapping without carry (59->0, 11->0).
  - al_adj: al_minutes +10. If the result is >= 60, subtract 60 and increment al_hours (11->0). Example: 50 -> 0 with hour +1.
- Priority: if tick_1hz coincides with any adjust pulse, the adjust is applied and the tick is latched in tick_pending. The pending tick is applied on the next cycle with no adjust pulse, so no tick is ever lost. Multiple adjust pulses in the same cycle all apply.
- Values that are never out of range need no clamping: out-of-range states are unreachable.
- Alarm FSM. match = (hours == al_hours) && (minutes == al_minutes).
  - IDLE: al_toggle -> ARMED.
  - ARMED: if match -> RINGING. Entry sets beep_phase = 1 and ring_cnt = 0.
  - RINGING: ring_cnt increments on each applied tick. At ring_cnt == RING_SECONDS-1 plus a tick -> DONE.
  - DONE: when !match -> ARMED, which prevents re-triggering within the same minute.
  - al_toggle in any non-IDLE state -> IDLE. The toggle has priority over every other transition in that cycle.
- beep_phase toggles on every tick_1hz (raw, not deferred).
- Tone: a free-running counter runs 0..TONE_HALF-1 and toggles tone at wrap.
- buzzer_out = ringing && beep_phase && tone, registered.
- bell_visible = al_on && (!ringing || beep_phase), so the bell blinks at 0.5 Hz while ringing.
- Reset mid-ring clears buzzer_out on the next edge.

Optional Feature:
TAC_SNOOZE_EN.
- Defined: an al_adj pulse in RINGING enters SNOOZE and does not change the alarm time. SNOOZE counts SNOOZE_SECONDS applied ticks, then returns to RINGING with ring_cnt reset to 0. al_toggle in SNOOZE -> IDLE. In SNOOZE, ringing = 0, buzzer_out = 0 and bell_visible = 1.
- Undefined: the SNOOZE state does not exist. al_adj always adjusts the alarm time in every state, and a ring continues until timeout or toggle.

Test Plan:
- Reset, then 3661 ticks -> hours = 1, minutes = 1, seconds = 1. Set 11:59:59 via adjusts, then 1 tick -> 0:00:00.
- seconds = 59 plus sec_adj -> seconds = 0 with minutes unchanged. Six al_adj pulses from 0:00 -> al_minutes = 0, al_hours = 1.
- tick_1hz and min_adj in the same cycle at 0:00:05 -> minutes = 1 after 1 cycle, seconds = 6 one cycle later.
- Alarm at 0:10, toggle on, advance to 0:10:00 -> ringing = 1 and buzzer_out toggles every 5000 clk in alternating seconds. After 60 ticks -> ringing = 0 with no re-ring at 0:10:xx. At 0:11 -> ARMED.
- While ringing, al_toggle -> al_on = 0, buzzer_out = 0 next cycle, bell_visible = 0. Reset asserted mid-ring -> all outputs 0.
- With TAC_SNOOZE_EN, al_adj while ringing -> buzzer silent for 120 ticks and al_minutes unchanged, then ringing = 1 again. Without it, the same pulse yields al_minutes +10.
